// File: rtl/interval_timer_pkg.sv
// Shared definitions for the two-channel interval timer: register offsets,
// CTRL/STATUS bit positions and the packed CTRL layout.
package pa_interval_timer;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_CH0_LO = 3'd2;
  localparam logic [2:0] ADDR_CH0_HI = 3'd3;
  localparam logic [2:0] ADDR_CH1_LO = 3'd4;
  localparam logic [2:0] ADDR_CH1_HI = 3'd5;
  localparam logic [2:0] ADDR_PRESC  = 3'd6;
  localparam logic [2:0] ADDR_RSVD   = 3'd7;

  localparam int unsigned CTRL_EN0   = 0;
  localparam int unsigned CTRL_EN1   = 1;
  localparam int unsigned CTRL_AUTO0 = 2;
  localparam int unsigned CTRL_AUTO1 = 3;
  localparam int unsigned CTRL_IE0   = 4;
  localparam int unsigned CTRL_IE1   = 5;

  localparam int unsigned STAT_TC0 = 0;
  localparam int unsigned STAT_TC1 = 1;

  typedef struct packed {
    logic ie1;
    logic ie0;
    logic auto1;
    logic auto0;
    logic en1;
    logic en0;
  } ctrl_t;

endpackage

// File: rtl/interval_timer_channel.sv
// One timer channel: 16-bit down-counter with reload register, read shadow
// for coherent 16-bit reads, and the sticky terminal-count flag.
module timer_channel
  import pa_interval_timer::*;
#(
  parameter logic [15:0] RELOAD_RST = 16'h0
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       tick_i,
  input  logic       en_i,
  input  logic       auto_i,
  input  logic       load_lo_i,
  input  logic       load_hi_i,
  input  logic       snap_i,
  input  logic       w1c_i,
  input  logic [7:0] data_i,
  output logic [7:0] count_lo_o,
  output logic [7:0] shadow_o,
  output logic       tc_o,
  output logic       expire_o
);

  logic [15:0] count_q, count_d;
  logic [15:0] reload_q, reload_d;
  logic [7:0]  shadow_q, shadow_d;
  logic        tc_q, tc_d;

  // A hi-byte load on a tick edge takes priority, so that edge never expires.
  assign expire_o = tick_i && en_i && !load_hi_i && (count_q == 16'd1);

  always_comb begin
    reload_d = reload_q;
    if (load_lo_i) begin
      reload_d[7:0] = data_i;
    end else if (load_hi_i) begin
      reload_d[15:8] = data_i;
    end else begin
      reload_d = reload_q;
    end

    if (load_hi_i) begin
      count_d = {data_i, reload_q[7:0]};
    end else if (tick_i && en_i && (count_q > 16'd1)) begin
      count_d = count_q - 16'd1;
    end else if (expire_o) begin
      count_d = auto_i ? reload_q : 16'd0;
    end else begin
      count_d = count_q;
    end

    shadow_d = snap_i ? count_q[15:8] : shadow_q;
    tc_d     = expire_o ? 1'b1 : (w1c_i ? 1'b0 : tc_q);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count_q  <= 16'd0;
      reload_q <= RELOAD_RST;
      shadow_q <= 8'd0;
      tc_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      shadow_q <= shadow_d;
      tc_q     <= tc_d;
    end
  end

  assign count_lo_o = count_q[7:0];
  assign shadow_o   = shadow_q;
  assign tc_o       = tc_q;

endmodule

// File: rtl/interval_timer.sv
// Two-channel 16-bit interval timer on the peripheral bus: bus decode with
// strobe edge detection, shared prescaler, CTRL register, read mux and irq.
module interval_timer
  import pa_interval_timer::*;
#(
  parameter logic [7:0]  PRESC_RST  = 8'd0,
  parameter logic [15:0] RELOAD_RST = 16'h0
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       ce_n,
  input  logic       oe_n,
  input  logic       we_n,
  input  logic [2:0] address,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq
);

  logic       wr_hist_q, rd_hist_q;
  logic       wr_act_s, rd_act_s, wr_stb_s, rd_stb_s;
  logic       wr_ctrl_s, wr_stat_s, wr_presc_s;
  logic [7:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic       tick_s;
  ctrl_t      ctrl_q, ctrl_d;
  logic       irq_q, irq_d;
  logic [1:0] en_s, tc_s, expire_s;
  logic [7:0] cnt_lo0_s, cnt_lo1_s, shadow0_s, shadow1_s, rdata_s;

  assign wr_act_s   = !ce_n && !we_n;
  assign rd_act_s   = !ce_n && !oe_n;
  assign wr_stb_s   = wr_act_s && !wr_hist_q;
  assign rd_stb_s   = rd_act_s && !rd_hist_q;
  assign wr_ctrl_s  = wr_stb_s && (address == ADDR_CTRL);
  assign wr_stat_s  = wr_stb_s && (address == ADDR_STATUS);
  assign wr_presc_s = wr_stb_s && (address == ADDR_PRESC);
  assign tick_s     = (pcnt_q == 8'd0);

  // A CTRL write that clears an enable suppresses the decrement on that edge.
  assign en_s[0] = ctrl_q.en0 && !(wr_ctrl_s && !data_in[CTRL_EN0]);
  assign en_s[1] = ctrl_q.en1 && !(wr_ctrl_s && !data_in[CTRL_EN1]);

  always_comb begin
    presc_d = wr_presc_s ? data_in : presc_q;
    if (wr_presc_s) begin
      pcnt_d = data_in;
    end else if (tick_s) begin
      pcnt_d = presc_q;
    end else begin
      pcnt_d = pcnt_q - 8'd1;
    end

    ctrl_d = ctrl_q;
    if (wr_ctrl_s) begin
      ctrl_d.en0   = data_in[CTRL_EN0];
      ctrl_d.en1   = data_in[CTRL_EN1];
      ctrl_d.auto0 = data_in[CTRL_AUTO0];
      ctrl_d.auto1 = data_in[CTRL_AUTO1];
      ctrl_d.ie0   = data_in[CTRL_IE0];
      ctrl_d.ie1   = data_in[CTRL_IE1];
    end else begin
      ctrl_d = ctrl_q;
    end
    ctrl_d.en0 = (expire_s[0] && !ctrl_q.auto0) ? 1'b0 : ctrl_d.en0;
    ctrl_d.en1 = (expire_s[1] && !ctrl_q.auto1) ? 1'b0 : ctrl_d.en1;

    irq_d = |(tc_s & {ctrl_q.ie1, ctrl_q.ie0});
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_hist_q <= 1'b0;
      rd_hist_q <= 1'b0;
      presc_q   <= PRESC_RST;
      pcnt_q    <= PRESC_RST;
      ctrl_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      wr_hist_q <= wr_act_s;
      rd_hist_q <= rd_act_s;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      ctrl_q    <= ctrl_d;
      irq_q     <= irq_d;
    end
  end

  timer_channel #(.RELOAD_RST(RELOAD_RST)) u_ch0 (
    .clk       (clk),
    .arst_n    (arst_n),
    .tick_i    (tick_s),
    .en_i      (en_s[0]),
    .auto_i    (ctrl_q.auto0),
    .load_lo_i (wr_stb_s && (address == ADDR_CH0_LO)),
    .load_hi_i (wr_stb_s && (address == ADDR_CH0_HI)),
    .snap_i    (rd_stb_s && (address == ADDR_CH0_LO)),
    .w1c_i     (wr_stat_s && data_in[STAT_TC0]),
    .data_i    (data_in),
    .count_lo_o(cnt_lo0_s),
    .shadow_o  (shadow0_s),
    .tc_o      (tc_s[0]),
    .expire_o  (expire_s[0])
  );

  timer_channel #(.RELOAD_RST(RELOAD_RST)) u_ch1 (
    .clk       (clk),
    .arst_n    (arst_n),
    .tick_i    (tick_s),
    .en_i      (en_s[1]),
    .auto_i    (ctrl_q.auto1),
    .load_lo_i (wr_stb_s && (address == ADDR_CH1_LO)),
    .load_hi_i (wr_stb_s && (address == ADDR_CH1_HI)),
    .snap_i    (rd_stb_s && (address == ADDR_CH1_LO)),
    .w1c_i     (wr_stat_s && data_in[STAT_TC1]),
    .data_i    (data_in),
    .count_lo_o(cnt_lo1_s),
    .shadow_o  (shadow1_s),
    .tc_o      (tc_s[1]),
    .expire_o  (expire_s[1])
  );

  always_comb begin
    case (address)
      ADDR_CTRL:   rdata_s = {2'b00, ctrl_q};
      ADDR_STATUS: rdata_s = {6'b000000, tc_s};
      ADDR_CH0_LO: rdata_s = cnt_lo0_s;
      ADDR_CH0_HI: rdata_s = shadow0_s;
      ADDR_CH1_LO: rdata_s = cnt_lo1_s;
      ADDR_CH1_HI: rdata_s = shadow1_s;
      ADDR_PRESC:  rdata_s = presc_q;
      ADDR_RSVD:   rdata_s = 8'h00;
      default:     rdata_s = 8'h00;
    endcase
  end

  assign data_out = rd_act_s ? rdata_s : 8'hzz;
  assign irq      = irq_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer: hand-timed bus accesses, expected values
// worked out per clock edge.
module tb_interval_timer;

  localparam logic [2:0] A_CTRL = 3'd0, A_STAT = 3'd1, A_C0L = 3'd2, A_C0H = 3'd3;
  localparam logic [2:0] A_C1L = 3'd4, A_C1H = 3'd5, A_PRE = 3'd6, A_RSV = 3'd7;

  logic       clk = 1'b0;
  logic       arst_n, ce_n, oe_n, we_n;
  logic [2:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       irq;
  logic [7:0] zz = 8'hzz;
  logic [7:0] dummy;
  int         n_vec = 0;
  int         n_err = 0;

  interval_timer dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .ce_n    (ce_n),
    .oe_n    (oe_n),
    .we_n    (we_n),
    .address (address),
    .data_in (data_in),
    .data_out(data_out),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input int hold);
    address = a; data_in = d; ce_n = 1'b0; we_n = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    ce_n = 1'b1; we_n = 1'b1;
  endtask

  task automatic wr1(input logic [2:0] a, input logic [7:0] d);
    wr(a, d, 1);
    tick(1);
  endtask

  // Read without crossing a clock edge: no side effect in the DUT.
  task automatic peek(input logic [2:0] a, output logic [7:0] v);
    address = a; ce_n = 1'b0; oe_n = 1'b0;
    #1;
    v = data_out;
    ce_n = 1'b1; oe_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] v);
    address = a; ce_n = 1'b0; oe_n = 1'b0;
    #1;
    v = data_out;
    @(posedge clk);
    #1;
    ce_n = 1'b1; oe_n = 1'b1;
  endtask

  task automatic pchk(input string tag, input logic [2:0] a, input logic [7:0] e);
    logic [7:0] v;
    peek(a, v);
    chk(tag, {8'h00, v}, {8'h00, e});
  endtask

  task automatic do_reset();
    arst_n = 1'b0; ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
    address = 3'd0; data_in = 8'h00;
    tick(2);
    arst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    logic [7:0] v;

    // Reset state and reserved register
    do_reset();
    chk("rst_irq", {15'd0, irq}, 16'd0);
    chk("rst_dout_z", {8'h00, data_out}, {8'h00, zz});
    pchk("rst_ctrl", A_CTRL, 8'h00);
    pchk("rst_stat", A_STAT, 8'h00);
    pchk("rst_c0l", A_C0L, 8'h00);
    pchk("rst_c0h", A_C0H, 8'h00);
    pchk("rst_presc", A_PRE, 8'h00);
    pchk("rst_rsvd", A_RSV, 8'h00);
    wr1(A_RSV, 8'hFF);
    pchk("rsvd_wr", A_RSV, 8'h00);
    pchk("rsvd_ctrl", A_CTRL, 8'h00);

    // 1: auto-reload every 5 clk, irq and W1C
    do_reset();
    wr1(A_C0L, 8'd5);
    wr1(A_C0H, 8'd0);
    wr1(A_CTRL, 8'h15);
    pchk("t1_ctrl", A_CTRL, 8'h15);
    pchk("t1_cnt4", A_C0L, 8'd4);
    tick(4);
    pchk("t1_tc", A_STAT, 8'h01);
    pchk("t1_reload", A_C0L, 8'd5);
    chk("t1_irq_lag", {15'd0, irq}, 16'd0);
    tick(1);
    chk("t1_irq", {15'd0, irq}, 16'd1);
    pchk("t1_cnt4b", A_C0L, 8'd4);
    wr1(A_STAT, 8'h01);
    chk("t1_irq_clr", {15'd0, irq}, 16'd0);
    pchk("t1_stat_clr", A_STAT, 8'h00);
    tick(1);
    pchk("t1_cnt1", A_C0L, 8'd1);
    pchk("t1_stat_pre", A_STAT, 8'h00);
    tick(1);
    pchk("t1_tc_again", A_STAT, 8'h01);
    pchk("t1_reload2", A_C0L, 8'd5);

    // 2: prescaled one-shot, hi write on a tick edge
    do_reset();
    wr1(A_C1L, 8'd2);
    wr1(A_PRE, 8'd3);
    wr1(A_CTRL, 8'h02);
    wr1(A_C1H, 8'd0);
    pchk("t2_load_tick", A_C1L, 8'd2);
    pchk("t2_presc", A_PRE, 8'd3);
    tick(3);
    pchk("t2_cnt1", A_C1L, 8'd1);
    tick(3);
    pchk("t2_no_tc", A_STAT, 8'h00);
    tick(1);
    pchk("t2_tc1", A_STAT, 8'h02);
    pchk("t2_en_clr", A_CTRL, 8'h00);
    pchk("t2_cnt0", A_C1L, 8'd0);
    chk("t2_irq", {15'd0, irq}, 16'd0);
    tick(8);
    pchk("t2_hold_cnt", A_C1L, 8'd0);
    pchk("t2_hold_tc", A_STAT, 8'h02);
    chk("t2_irq_hold", {15'd0, irq}, 16'd0);

    // 3: coherent 16-bit read across 0x1200
    do_reset();
    wr1(A_C0L, 8'h01);
    wr1(A_C0H, 8'h12);
    wr1(A_CTRL, 8'h01);
    rd(A_C0L, v);
    chk("t3_lo", {8'h00, v}, 16'h0000);
    tick(1);
    rd(A_C0H, v);
    chk("t3_hi_shadow", {8'h00, v}, 16'h0012);
    pchk("t3_live_lo", A_C0L, 8'hFD);

    // 4: held strobes act once
    do_reset();
    wr1(A_C0L, 8'd3);
    wr1(A_C0H, 8'd0);
    wr1(A_CTRL, 8'h05);
    tick(3);
    pchk("t4_tc_pre", A_STAT, 8'h01);
    wr(A_STAT, 8'h01, 4);
    pchk("t4_w1c_once", A_STAT, 8'h01);
    tick(1);
    wr(A_C0H, 8'h01, 4);
    pchk("t4_hi_once", A_C0L, 8'h00);
    tick(1);

    // 5: tc set and W1C on the same edge
    do_reset();
    wr1(A_C0L, 8'd3);
    wr1(A_C0H, 8'd0);
    wr1(A_CTRL, 8'h01);
    tick(1);
    wr1(A_STAT, 8'h01);
    pchk("t5_set_wins", A_STAT, 8'h01);
    wr1(A_STAT, 8'h01);
    pchk("t5_w1c", A_STAT, 8'h00);

    // 6: asynchronous reset mid-count
    do_reset();
    wr1(A_PRE, 8'd2);
    wr1(A_C1L, 8'h34);
    wr1(A_C1H, 8'h12);
    wr1(A_C0L, 8'd1);
    wr1(A_C0H, 8'd0);
    wr1(A_CTRL, 8'hFF);
    rd(A_C1L, dummy);
    tick(10);
    chk("t6_irq_pre", {15'd0, irq}, 16'd1);
    pchk("t6_ctrl_pre", A_CTRL, 8'h3F);
    pchk("t6_shadow_pre", A_C1H, 8'h12);
    arst_n = 1'b0;
    #1;
    chk("t6_irq_rst", {15'd0, irq}, 16'd0);
    chk("t6_dout_z", {8'h00, data_out}, {8'h00, zz});
    tick(1);
    pchk("t6_ctrl", A_CTRL, 8'h00);
    pchk("t6_stat", A_STAT, 8'h00);
    pchk("t6_c1l", A_C1L, 8'h00);
    pchk("t6_c1h", A_C1H, 8'h00);
    pchk("t6_presc", A_PRE, 8'h00);
    arst_n = 1'b1;
    tick(1);
    wr1(A_C1H, 8'h00);
    pchk("t6_reload_rst", A_C1L, 8'h00);
    chk("t6_irq_post", {15'd0, irq}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
